icf3z_uart_tx: RTL and testbench

Port-mapped UART transmitter that sits directly downstream of the icf3z core on its I/O bus. It decodes PORTID, accepts bytes on OUTPORT with WSTROBE, buffers them in a 16-entry FIFO, and serialises them as 8N1 frames on TXD. It returns status and configuration to the core's INPORT mux and raises a level interrupt intended for the core's INT0 input.

---
 rtl/icf3z_io_pkg.sv | 15 +
 rtl/icf3z_sync_fifo.sv | 36 +++
 rtl/icf3z_uart_tx.sv | 119 +++++++++++
 tb/tb_icf3z_uart_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/icf3z_io_pkg.sv
// icf3z_io_pkg: register map, bit indices and transmit FSM states for the icf3z UART
package icf3z_io_pkg;
  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_DIVL = 2'd1;
  localparam logic [1:0] UART_DIVH = 2'd2;
  localparam logic [1:0] UART_CTRL = 2'd3;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int CT_EN  = 0;
  localparam int CT_IE  = 1;
  localparam int CT_CLR = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/icf3z_sync_fifo.sv
// icf3z_sync_fifo: show-ahead synchronous FIFO; read-first so push+pop while full is legal
module icf3z_sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign empty  = r_cnt == '0;
  assign full   = r_cnt == (AW+1)'(2**AW);
  assign dout   = r_mem[r_rp];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + AW'(1) : r_rp;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/icf3z_uart_tx.sv
// icf3z_uart_tx: port-mapped 8N1 UART transmitter with 16-deep FIFO, status readback
// and level interrupt for the icf3z core I/O bus.
module icf3z_uart_tx
  import icf3z_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         FIFO_AW   = 4,
  parameter int         DIV_W     = 16
) (
  input  logic       CLK,
  input  logic       xRESET_N,
  input  logic [7:0] PORTID,
  input  logic [7:0] OUTPORT,
  input  logic       WSTROBE,
  input  logic       RSTROBE,
  output logic [7:0] INDATA,
  output logic       RDSEL,
  output logic       TXD,
  output logic       INT_P
);
  logic [7:0]       w_off, w_status, w_dout, r_sh;
  logic [1:0]       w_reg;
  logic             w_wr, w_push, w_pop, w_clr, w_set, w_empty, w_full, w_busy, w_tick, w_go;
  logic             r_en, r_ie, r_ovf, r_txd;
  logic [DIV_W-1:0] r_div, r_cnt;
  logic [2:0]       r_bit;
  tx_state_t        r_state, w_next;

  assign w_off  = PORTID - BASE_ADDR;
  assign w_reg  = w_off[1:0];
  assign RDSEL  = w_off < 8'd4;
  assign w_wr   = WSTROBE & RDSEL;
  assign w_push = w_wr && w_reg == UART_DATA;
  assign w_clr  = (RSTROBE && RDSEL && w_reg == UART_DATA) ||
                  (w_wr && w_reg == UART_CTRL && OUTPORT[CT_CLR]);
  assign w_set  = w_push & w_full & ~w_pop;
  assign w_busy = r_state != IDLE;
  assign w_tick = r_cnt == '0;
  assign w_go   = r_en & ~w_empty;
  assign TXD    = r_txd;
  assign INT_P  = r_ie & w_empty & ~w_busy;

  always_comb begin
    w_status           = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_BUSY]  = w_busy;
    w_status[ST_OVF]   = r_ovf;
  end

  assign INDATA = !RDSEL              ? 8'h00 :
                  w_reg == UART_DATA ? w_status :
                  w_reg == UART_DIVL ? r_div[7:0] :
                  w_reg == UART_DIVH ? r_div[15:8] : {6'b0, r_ie, r_en};

  icf3z_sync_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk  (CLK),
    .rst_n(xRESET_N),
    .push (w_push),
    .pop  (w_pop),
    .din  (OUTPORT),
    .dout (w_dout),
    .empty(w_empty),
    .full (w_full)
  );

  always_ff @(posedge CLK or negedge xRESET_N)
    if (!xRESET_N) begin
      r_div <= '0;
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && w_reg == UART_DIVL) r_div[7:0] <= OUTPORT;
      if (w_wr && w_reg == UART_DIVH) r_div[15:8] <= OUTPORT;
      if (w_wr && w_reg == UART_CTRL) begin
        r_en <= OUTPORT[CT_EN];
        r_ie <= OUTPORT[CT_IE];
      end
      r_ovf <= w_set | (r_ovf & ~w_clr);
    end

  // Pops are issued only from IDLE or at the end of a stop bit, which gives back-to-back frames.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE:  if (w_go) begin w_next = START; w_pop = 1'b1; end
      START: if (w_tick) w_next = DATA;
      DATA:  if (w_tick && r_bit == 3'd7) w_next = STOP;
      STOP:  if (w_tick) begin w_next = w_go ? START : IDLE; w_pop = w_go; end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge xRESET_N)
    if (!xRESET_N) begin
      r_state <= IDLE;
      r_txd   <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE || w_tick) ? r_div : r_cnt - DIV_W'(1);
      if (w_pop) begin
        r_sh  <= w_dout;
        r_txd <= 1'b0;
      end else if (w_tick && r_state == START) begin
        r_txd <= r_sh[0];
        r_sh  <= r_sh >> 1;
        r_bit <= '0;
      end else if (w_tick && r_state == DATA) begin
        r_txd <= r_bit == 3'd7 ? 1'b1 : r_sh[0];
        r_sh  <= r_sh >> 1;
        r_bit <= r_bit + 3'd1;
      end
    end
endmodule

// File: tb/tb_icf3z_uart_tx.sv
// tb_icf3z_uart_tx: directed and randomized bus traffic against a frame-level model of the UART
module tb_icf3z_uart_tx;
  logic       CLK = 1'b0;
  logic       xRESET_N = 1'b0;
  logic [7:0] PORTID = 8'h00;
  logic [7:0] OUTPORT = 8'h00;
  logic       WSTROBE = 1'b0;
  logic       RSTROBE = 1'b0;
  logic [7:0] INDATA;
  logic       RDSEL, TXD, INT_P;

  int checks = 0;
  int failures = 0;

  icf3z_uart_tx #(.BASE_ADDR(8'h10), .FIFO_AW(4), .DIV_W(16)) dut (
    .CLK(CLK), .xRESET_N(xRESET_N), .PORTID(PORTID), .OUTPORT(OUTPORT),
    .WSTROBE(WSTROBE), .RSTROBE(RSTROBE), .INDATA(INDATA), .RDSEL(RDSEL),
    .TXD(TXD), .INT_P(INT_P)
  );

  initial forever #5 CLK = ~CLK;

  // Model: a byte queue plus the frame in flight, described by its byte, bit time and elapsed clocks.
  logic [7:0]  q[$];
  logic        m_en = 0, m_ie = 0, m_ovf = 0, m_act = 0;
  logic [15:0] m_div = 0, m_d = 0;
  logic [7:0]  m_byte = 0;
  int          m_t = 0;
  logic [7:0]  md_off, c_off;
  logic        md_sel, md_wr, md_set, md_clr;

  function automatic logic m_txd();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_t / (int'(m_d) + 1);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic logic [7:0] m_indata(input logic [7:0] pid);
    logic [7:0] off;
    off = pid - 8'h10;
    case (off)
      8'd0: return {4'b0, m_ovf, m_act, q.size() == 16, q.size() == 0};
      8'd1: return m_div[7:0];
      8'd2: return m_div[15:8];
      8'd3: return {6'b0, m_ie, m_en};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge xRESET_N);
    if (!xRESET_N) begin
      q.delete();
      m_en = 0; m_ie = 0; m_ovf = 0; m_act = 0; m_div = 0; m_t = 0;
    end else begin
      if (m_act) begin
        if (m_t == 10 * (int'(m_d) + 1) - 1) m_act = 0;
        else m_t++;
      end
      if (!m_act && m_en && q.size() > 0) begin
        m_byte = q.pop_front();
        m_t = 0;
        m_d = m_div;
        m_act = 1;
      end
      md_off = PORTID - 8'h10;
      md_sel = md_off < 8'd4;
      md_wr  = WSTROBE && md_sel;
      md_set = 0;
      md_clr = (RSTROBE && md_sel && md_off == 0) || (md_wr && md_off == 3 && OUTPORT[3]);
      if (md_wr && md_off == 0) begin
        if (q.size() < 16) q.push_back(OUTPORT);
        else md_set = 1;
      end
      m_ovf = md_set || (m_ovf && !md_clr);
      if (md_wr && md_off == 1) m_div[7:0] = OUTPORT;
      if (md_wr && md_off == 2) m_div[15:8] = OUTPORT;
      if (md_wr && md_off == 3) begin
        m_en = OUTPORT[0];
        m_ie = OUTPORT[1];
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (xRESET_N) begin
      c_off = PORTID - 8'h10;
      chk("txd", 8'(TXD), 8'(m_txd()));
      chk("int_p", 8'(INT_P), 8'(m_ie && q.size() == 0 && !m_act));
      chk("rdsel", 8'(RDSEL), 8'(c_off < 8'd4));
      chk("indata", INDATA, m_indata(PORTID));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    PORTID = a; OUTPORT = d; WSTROBE = 1'b1;
    tick();
    WSTROBE = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string name);
    PORTID = a;
    @(negedge CLK);
    chk(name, INDATA, exp);
    tick();
  endtask

  task automatic rdc(input logic [7:0] a, input logic [7:0] exp, input string name);
    PORTID = a; RSTROBE = 1'b1;
    @(negedge CLK);
    chk(name, INDATA, exp);
    tick();
    RSTROBE = 1'b0;
  endtask

  logic [9:0] f_a5 = 10'b1101001010;
  logic [9:0] f_5e = 10'b1010111100;

  initial begin
    int fv, bt;
    logic e;
    repeat (3) @(posedge CLK);
    #1 xRESET_N = 1'b1;
    wr(8'h13, 8'h01);
    wr(8'h10, 8'h3C);
    repeat (4) tick();
    xRESET_N = 1'b0;
    #1;
    chk("rst_txd", 8'(TXD), 8'h01);
    chk("rst_int", 8'(INT_P), 8'h00);
    repeat (2) @(posedge CLK);
    #1 xRESET_N = 1'b1;
    peek(8'h10, 8'h01, "rst_status");

    wr(8'h11, 8'h00); wr(8'h12, 8'h00); wr(8'h13, 8'h01); wr(8'h10, 8'hA5);
    for (int j = 1; j <= 11; j++) begin
      @(negedge CLK);
      e = (j == 1) ? 1'b1 : f_a5[j-2];
      chk("single_txd", 8'(TXD), 8'(e));
      if (j == 11) chk("single_busy", INDATA, 8'h05);
    end
    @(negedge CLK);
    chk("single_done", INDATA, 8'h01);
    tick();

    wr(8'h11, 8'h03); wr(8'h10, 8'h5E);
    for (int j = 1; j <= 41; j++) begin
      @(negedge CLK);
      e = (j == 1) ? 1'b1 : f_5e[(j-2)/4];
      chk("div_txd", 8'(TXD), 8'(e));
      if (j == 41) chk("div_last", INDATA, 8'h05);
    end
    @(negedge CLK);
    chk("div_done", INDATA, 8'h01);
    tick();

    wr(8'h11, 8'h00); wr(8'h13, 8'h00);
    for (int i = 0; i <= 16; i++) wr(8'h10, 8'(i));
    peek(8'h10, 8'h0A, "ovf_status");
    rdc(8'h10, 8'h0A, "ovf_rd");
    peek(8'h10, 8'h02, "ovf_clr");
    wr(8'h13, 8'h01);
    for (int j = 1; j <= 161; j++) begin
      @(negedge CLK);
      fv = (j - 2) / 10;
      bt = (j - 2) % 10;
      e = (j == 1) ? 1'b1 : bt == 0 ? 1'b0 : bt == 9 ? 1'b1 : fv[bt-1];
      chk("ovf_txd", 8'(TXD), 8'(e));
    end
    @(negedge CLK);
    chk("ovf_done", INDATA, 8'h01);
    tick();

    wr(8'h13, 8'h03);
    @(negedge CLK);
    chk("int_idle", 8'(INT_P), 8'h01);
    tick();
    wr(8'h10, 8'hC3);
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLK);
      chk("int_frame", 8'(INT_P), 8'(j == 12));
    end
    tick();

    wr(8'h11, 8'h03); wr(8'h13, 8'h01); wr(8'h10, 8'h81); wr(8'h10, 8'h7E);
    repeat (12) tick();
    wr(8'h13, 8'h00);
    repeat (40) tick();
    @(negedge CLK);
    chk("en_clr_txd", 8'(TXD), 8'h01);
    tick();
    peek(8'h10, 8'h00, "en_clr_status");

    for (int n = 0; n < 3000; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) wr(8'h10, 8'($urandom));
      else if (op == 3) begin
        PORTID = 8'h10; RSTROBE = 1'b1;
        tick();
        RSTROBE = 1'b0;
      end else if (op == 4)
        wr(8'h13, {4'b0, $urandom_range(0, 3) == 0, 1'b0, 1'($urandom), $urandom_range(0, 3) != 0});
      else if (op == 5 && !m_act)
        wr($urandom_range(0, 3) == 0 ? 8'h12 : 8'h11, $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom_range(0, 2)));
      else if (op == 6)
        wr($urandom_range(0, 1) ? 8'h0F : 8'h14, 8'($urandom));
      else begin
        PORTID = 8'($urandom_range(8'h0C, 8'h17));
        tick();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
